multicycle_control: RTL



---
 rtl/mc_ctrl_pkg.sv | 57 +++++
 rtl/mc_ctrl_dispatch.sv | 29 ++
 rtl/multicycle_control.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM.
// Pure type/constant package: no latency, no flow control.
package mc_ctrl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        START     = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXEC      = 4'd7,
        R_WB      = 4'd8,
        ADDI_EXEC = 4'd9,
        ADDI_WB   = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        JAL       = 4'd13,
        JR        = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

endpackage

// File: rtl/mc_ctrl_dispatch.sv
// Maps opcode/funct to the state that follows DECODE, flagging unsupported codes.
// Purely combinational; no flow control.
module mc_ctrl_dispatch
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    output logic [STATE_W-1:0] decode_next,
    output logic               illegal
);

    always_comb begin
        decode_next = FETCH;
        illegal     = 1'b0;
        case (opcode)
            OP_RTYPE:      decode_next = (funct == FN_JR) ? JR : EXEC;
            OP_ADDI:       decode_next = ADDI_EXEC;
            OP_LW, OP_SW:  decode_next = MEM_ADDR;
            OP_BEQ, OP_BNE: decode_next = BRANCH;
            OP_J:          decode_next = JUMP;
            OP_JAL:        decode_next = JAL;
            default: begin
                decode_next = FETCH;
                illegal     = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath plus retired-instruction counter.
// 3-5 cycles per instruction; stalls in FETCH/MEM_READ/MEM_WRITE until mem_ready.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             NEqual,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic             inst_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] inst_count
);

    state_t             state, next_state;
    logic [STATE_W-1:0] decode_next;
    logic               decode_illegal;

    mc_ctrl_dispatch u_dispatch (
        .opcode      (opcode),
        .funct       (funct),
        .decode_next (decode_next),
        .illegal     (decode_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= START;
            inst_count <= '0;
        end else begin
            state <= next_state;
            if (inst_done)
                inst_count <= inst_count + CNT_W'(1);
        end
    end

    always_comb begin
        next_state  = state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        NEqual      = 1'b0;
        ALUOp       = ALUOP_ADD;
        ALUSrcB     = SRCB_REGB;
        PCSource    = PCSRC_ALU;
        RegDst      = REGDST_RT;
        MemtoReg    = M2R_ALUOUT;
        inst_done   = 1'b0;
        illegal_op  = 1'b0;

        case (state)
            START: next_state = FETCH;

            FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                // IR and PC+4 are only captured on the cycle the read completes
                IRWrite  = mem_ready;
                PCWrite  = mem_ready;
                if (mem_ready)
                    next_state = DECODE;
            end

            DECODE: begin
                ALUSrcB    = SRCB_IMM_SH2;
                illegal_op = decode_illegal;
                next_state = state_t'(decode_next);
            end

            MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                next_state = opcode[3] ? MEM_WRITE : MEM_READ;
            end

            MEM_READ: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready)
                    next_state = MEM_WB;
            end

            MEM_WB: begin
                RegWrite   = 1'b1;
                RegDst     = REGDST_RT;
                MemtoReg   = M2R_MDR;
                inst_done  = 1'b1;
                next_state = FETCH;
            end

            MEM_WRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    inst_done  = 1'b1;
                    next_state = FETCH;
                end
            end

            EXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_REGB;
                ALUOp      = ALUOP_FUNCT;
                next_state = R_WB;
            end

            R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = REGDST_RD;
                MemtoReg   = M2R_ALUOUT;
                inst_done  = 1'b1;
                next_state = FETCH;
            end

            ADDI_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                next_state = ADDI_WB;
            end

            ADDI_WB: begin
                RegWrite   = 1'b1;
                RegDst     = REGDST_RT;
                MemtoReg   = M2R_ALUOUT;
                inst_done  = 1'b1;
                next_state = FETCH;
            end

            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_REGB;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                NEqual      = opcode[0];
                inst_done   = 1'b1;
                next_state  = FETCH;
            end

            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                inst_done  = 1'b1;
                next_state = FETCH;
            end

            JAL: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                RegWrite   = 1'b1;
                RegDst     = REGDST_RA;
                MemtoReg   = M2R_PC;
                inst_done  = 1'b1;
                next_state = FETCH;
            end

            JR: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_RS;
                inst_done  = 1'b1;
                next_state = FETCH;
            end

            default: next_state = START;
        endcase
    end

endmodule
